if_fetch_queue: RTL

Instruction-fetch stage directly downstream of the PC generator. Each cycle it issues the current PC to a synchronous instruction memory with one-cycle read latency. It captures the returned word with its PC into a small FIFO and presents it to decode through a valid/ready handshake. It drives the PC generator's hold input so that no fetched instruction is ever dropped, and discards wrong-path instructions on a flush.

---
 rtl/if_fetch_queue.sv | 75 +++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: issues pc_in to a one-cycle-latency imem, queues {pc, inst} for decode, holds the PC gen when full.
module if_fetch_queue #(
    parameter int PC_WIDTH   = 12,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic                  flush,
    output logic                  fetch_hold,
    output logic                  imem_en,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    input  logic                  inst_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int AW = $clog2(DEPTH);
    logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem_d   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_d [DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  if_vld_q, if_vld_d;
    logic [PC_WIDTH-1:0]   if_pc_q, if_pc_d;
    logic                  pop, push;
    logic [OW-1:0]         occ;
    // The in-flight request counts against capacity so its returning word always has a slot.
    always_comb begin
        inst_valid = !rst && !flush && (count_q != '0);
        pop        = inst_valid && inst_ready;
        push       = if_vld_q && !flush;
        occ        = OW'(count_q) + OW'(if_vld_q);
        fetch_hold = !rst && !flush && ((occ - OW'(pop)) >= OW'(DEPTH));
        imem_en    = !rst && !flush && !fetch_hold;
        imem_addr  = pc_in;
        inst       = inst_mem_q[rd_ptr_q];
        inst_pc    = pc_mem_q[rd_ptr_q];
    end
    always_comb begin
        if_vld_d   = imem_en;
        if_pc_d    = pc_in;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]   = if_pc_q;
            inst_mem_d[wr_ptr_q] = imem_rdata;
        end
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            if_vld_q <= 1'b0;
            if_pc_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if_vld_q <= if_vld_d;
            if_pc_q  <= if_pc_d;
        end
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end
endmodule
